// File: rtl/csp_arb_pkg.sv
// Shared types and constants for the CSP clocked fair arbiter.
// Optional macro CSP_ARB_RANDOM_TIEBREAK_EN selects LFSR tie-breaking instead of the rotating pointer.
package csp_arb_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // x^16+x^14+x^13+x^11+1 in right-shifting Galois form
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
      logic [15:0] nxt;
      nxt = {1'b0, cur[15:1]};
      if (cur[0]) begin
         nxt = nxt ^ LFSR_TAPS;
      end else begin
         nxt = nxt;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/csp_arb_pick.sv
// Combinational winner selection: longest-waiting true guard, ties broken by pointer or LFSR.
// Optional macro CSP_ARB_RANDOM_TIEBREAK_EN swaps the ptr input for an LFSR value.
module csp_arb_pick
   import csp_arb_pkg::*;
#(
   parameter int GUARDS = 4,
   parameter int CNT_W  = 8,
   parameter int IDX_W  = idx_width(GUARDS)
) (
   input  logic [GUARDS-1:0]       req,
   input  logic [GUARDS*CNT_W-1:0] cnt,
`ifdef CSP_ARB_RANDOM_TIEBREAK_EN
   input  logic [15:0]             lfsr,
`else
   input  logic [IDX_W-1:0]        ptr,
`endif
   output logic [IDX_W-1:0]        winner_idx,
   output logic [GUARDS-1:0]       winner_onehot
);

   logic [CNT_W-1:0]  max_cnt_s;
   logic [GUARDS-1:0] cand_s;
   logic              found_s;

   // Find the largest wait count among true guards and mark every true guard holding it.
   always_comb begin
      max_cnt_s = '0;
      cand_s    = '0;
      for (int g = 0; g < GUARDS; g++) begin
         if (req[g] && (cnt[g*CNT_W +: CNT_W] > max_cnt_s)) begin
            max_cnt_s = cnt[g*CNT_W +: CNT_W];
         end else begin
            max_cnt_s = max_cnt_s;
         end
      end
      for (int g = 0; g < GUARDS; g++) begin
         cand_s[g] = req[g] && (cnt[g*CNT_W +: CNT_W] == max_cnt_s);
      end
   end

`ifdef CSP_ARB_RANDOM_TIEBREAK_EN
   int num_cand_s;
   int target_s;
   int seen_s;

   // Take candidate number (lfsr mod candidate count), counting upward from guard 0.
   always_comb begin
      num_cand_s = 0;
      seen_s     = 0;
      found_s    = 1'b0;
      winner_idx = '0;
      for (int g = 0; g < GUARDS; g++) begin
         if (cand_s[g]) begin
            num_cand_s = num_cand_s + 1;
         end else begin
            num_cand_s = num_cand_s;
         end
      end
      target_s = (num_cand_s > 0) ? (int'(lfsr) % num_cand_s) : 0;
      for (int g = 0; g < GUARDS; g++) begin
         if (cand_s[g]) begin
            if (!found_s && (seen_s == target_s)) begin
               winner_idx = IDX_W'(g);
               found_s    = 1'b1;
            end else begin
               found_s = found_s;
            end
            seen_s = seen_s + 1;
         end else begin
            seen_s = seen_s;
         end
      end
   end
`else
   // First candidate scanning upward from ptr, wrapping at GUARDS.
   always_comb begin
      found_s    = 1'b0;
      winner_idx = '0;
      for (int k = 0; k < GUARDS; k++) begin
         if (!found_s && cand_s[(int'(ptr) + k) % GUARDS]) begin
            winner_idx = IDX_W'((int'(ptr) + k) % GUARDS);
            found_s    = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end
`endif

   // One-hot form of the winner; all zero when no guard is true.
   always_comb begin
      winner_onehot = '0;
      if (|cand_s) begin
         winner_onehot[winner_idx] = 1'b1;
      end else begin
         winner_onehot = '0;
      end
   end

endmodule

// File: rtl/csp_clocked_fair_arbiter.sv
// Clocked fair arbiter for CSP guarded selection: grants one true guard and holds it until release.
// Optional macro CSP_ARB_RANDOM_TIEBREAK_EN enables LFSR tie-breaking in place of the rotating pointer.
module csp_clocked_fair_arbiter
   import csp_arb_pkg::*;
#(
   parameter int GUARDS = 4,
   parameter int CNT_W  = 8,
   parameter int IDX_W  = idx_width(GUARDS)
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [GUARDS-1:0] req,
   input  logic              release_pulse,
   output logic [GUARDS-1:0] grant,
   output logic              grant_valid,
   output logic [IDX_W-1:0]  grant_idx,
   output logic              busy
);

   arb_state_e              state_r, state_nxt_s;
   logic [GUARDS-1:0]       grant_r, grant_nxt_s;
   logic [IDX_W-1:0]        idx_r, idx_nxt_s;
   logic                    valid_r;
   logic [GUARDS*CNT_W-1:0] cnt_r, cnt_nxt_s;
   logic [IDX_W-1:0]        win_idx_s;
   logic [GUARDS-1:0]       win_oh_s;
   logic                    arb_s;
`ifdef CSP_ARB_RANDOM_TIEBREAK_EN
   logic [15:0]             lfsr_r, lfsr_nxt_s;
`else
   logic [IDX_W-1:0]        ptr_r, ptr_nxt_s;
`endif

   csp_arb_pick #(
      .GUARDS (GUARDS),
      .CNT_W  (CNT_W),
      .IDX_W  (IDX_W)
   ) u_pick (
      .req           (req),
      .cnt           (cnt_r),
`ifdef CSP_ARB_RANDOM_TIEBREAK_EN
      .lfsr          (lfsr_r),
`else
      .ptr           (ptr_r),
`endif
      .winner_idx    (win_idx_s),
      .winner_onehot (win_oh_s)
   );

   // Next state, grant and fairness updates; counters move only on an arbitration edge.
   always_comb begin
      state_nxt_s = state_r;
      grant_nxt_s = grant_r;
      idx_nxt_s   = idx_r;
      cnt_nxt_s   = cnt_r;
      arb_s       = 1'b0;
`ifndef CSP_ARB_RANDOM_TIEBREAK_EN
      ptr_nxt_s   = ptr_r;
`endif
      case (state_r)
         IDLE: begin
            if (|req) begin
               arb_s       = 1'b1;
               state_nxt_s = GRANT;
               grant_nxt_s = win_oh_s;
               idx_nxt_s   = win_idx_s;
               for (int g = 0; g < GUARDS; g++) begin
                  if (g == int'(win_idx_s)) begin
                     cnt_nxt_s[g*CNT_W +: CNT_W] = '0;
                  end else if (req[g]) begin
                     if (cnt_r[g*CNT_W +: CNT_W] == {CNT_W{1'b1}}) begin
                        cnt_nxt_s[g*CNT_W +: CNT_W] = cnt_r[g*CNT_W +: CNT_W];
                     end else begin
                        cnt_nxt_s[g*CNT_W +: CNT_W] = cnt_r[g*CNT_W +: CNT_W] + {{(CNT_W-1){1'b0}}, 1'b1};
                     end
                  end else begin
                     cnt_nxt_s[g*CNT_W +: CNT_W] = '0;
                  end
               end
`ifndef CSP_ARB_RANDOM_TIEBREAK_EN
               ptr_nxt_s = (win_idx_s == IDX_W'(GUARDS - 1)) ? '0 : (win_idx_s + {{(IDX_W-1){1'b0}}, 1'b1});
`endif
            end else begin
               state_nxt_s = IDLE;
            end
         end
         // The committed branch keeps its grant regardless of req until it releases.
         GRANT: begin
            if (release_pulse) begin
               state_nxt_s = IDLE;
               grant_nxt_s = '0;
               idx_nxt_s   = '0;
            end else begin
               state_nxt_s = GRANT;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            grant_nxt_s = '0;
            idx_nxt_s   = '0;
         end
      endcase
   end

`ifdef CSP_ARB_RANDOM_TIEBREAK_EN
   assign lfsr_nxt_s = arb_s ? lfsr_step(lfsr_r) : lfsr_r;
`endif

   // State, grant and fairness registers; RESET clears all of them, even mid-grant.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_r <= IDLE;
         grant_r <= '0;
         idx_r   <= '0;
         valid_r <= 1'b0;
         cnt_r   <= '0;
`ifdef CSP_ARB_RANDOM_TIEBREAK_EN
         lfsr_r  <= LFSR_SEED;
`else
         ptr_r   <= '0;
`endif
      end else begin
         state_r <= state_nxt_s;
         grant_r <= grant_nxt_s;
         idx_r   <= idx_nxt_s;
         valid_r <= (state_nxt_s == GRANT);
         cnt_r   <= cnt_nxt_s;
`ifdef CSP_ARB_RANDOM_TIEBREAK_EN
         lfsr_r  <= lfsr_nxt_s;
`else
         ptr_r   <= ptr_nxt_s;
`endif
      end
   end

   assign grant       = grant_r;
   assign grant_valid = valid_r;
   assign grant_idx   = idx_r;
   assign busy        = valid_r;

endmodule

// File: tb/tb_csp_clocked_fair_arbiter.sv
// Self-checking bench: a 4-guard/8-bit instance and an 8-guard/2-bit instance against a reference model.
module tb_csp_clocked_fair_arbiter;

   logic       CLK = 1'b0;
   logic       RESET;
   logic [3:0] req4;
   logic       rel4;
   logic [3:0] grant4;
   logic       valid4;
   logic [1:0] idx4;
   logic       busy4;
   logic [7:0] req8;
   logic       rel8;
   logic [7:0] grant8;
   logic       valid8;
   logic [2:0] idx8;
   logic       busy8;

   int err_cnt = 0;
   int chk_cnt = 0;

   int m_cnt [2][8];
   int m_ptr [2];
   bit m_valid [2];
   int m_idx [2];
   bit prev_v [2];
   int sb_q0 [$];
   int sb_q1 [$];

   always #5 CLK = ~CLK;

   csp_clocked_fair_arbiter #(.GUARDS(4), .CNT_W(8)) dut4 (
      .CLK(CLK), .RESET(RESET), .req(req4), .release_pulse(rel4),
      .grant(grant4), .grant_valid(valid4), .grant_idx(idx4), .busy(busy4)
   );

   csp_clocked_fair_arbiter #(.GUARDS(8), .CNT_W(2)) dut8 (
      .CLK(CLK), .RESET(RESET), .req(req8), .release_pulse(rel8),
      .grant(grant8), .grant_valid(valid8), .grant_idx(idx8), .busy(busy8)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model of one arbitration edge for instance d (0: 4 guards/max 255, 1: 8 guards/max 3).
   task automatic model_edge(input int d, input logic rst, input logic [7:0] r, input logic rel);
      int gn, cmax, best, win, p;
      gn   = (d == 0) ? 4 : 8;
      cmax = (d == 0) ? 255 : 3;
      if (rst) begin
         for (int g = 0; g < 8; g++) m_cnt[d][g] = 0;
         m_ptr[d] = 0; m_valid[d] = 1'b0; m_idx[d] = 0;
      end else if (!m_valid[d]) begin
         if (r != 8'd0) begin
            best = -1;
            for (int g = 0; g < gn; g++)
               if (r[g] && m_cnt[d][g] > best) best = m_cnt[d][g];
            win = -1;
            for (int k = 0; k < gn; k++) begin
               p = (m_ptr[d] + k) % gn;
               if (win < 0 && r[p] && m_cnt[d][p] == best) win = p;
            end
            for (int g = 0; g < gn; g++) begin
               if (g == win) m_cnt[d][g] = 0;
               else if (r[g]) m_cnt[d][g] = (m_cnt[d][g] < cmax) ? m_cnt[d][g] + 1 : cmax;
               else m_cnt[d][g] = 0;
            end
            m_ptr[d] = (win + 1) % gn;
            m_valid[d] = 1'b1;
            m_idx[d] = win;
            if (d == 0) sb_q0.push_back(win); else sb_q1.push_back(win);
         end
      end else if (rel) begin
         m_valid[d] = 1'b0;
         m_idx[d] = 0;
      end
   endtask

   always @(posedge CLK) begin
      model_edge(0, RESET, {4'd0, req4}, rel4);
      model_edge(1, RESET, req8, rel8);
   end

   task automatic check_outputs(input int d, input logic v, input logic [7:0] g,
                                input logic [7:0] ix, input logic b);
      logic [7:0] eg;
      int exp_idx;
      eg = m_valid[d] ? (8'd1 << m_idx[d]) : 8'd0;
      check_eq((d == 0) ? "valid4" : "valid8", {31'd0, v}, {31'd0, m_valid[d]});
      check_eq((d == 0) ? "grant4" : "grant8", {24'd0, g}, {24'd0, eg});
      check_eq((d == 0) ? "busy4" : "busy8", {31'd0, b}, {31'd0, m_valid[d]});
      check_eq((d == 0) ? "idx4" : "idx8", {24'd0, ix}, m_valid[d] ? m_idx[d] : 0);
      if (v === 1'b1 && !prev_v[d]) begin
         if (((d == 0) ? sb_q0.size() : sb_q1.size()) == 0) begin
            check_eq("sb_unexpected_grant", 32'd1, 32'd0);
         end else begin
            exp_idx = (d == 0) ? sb_q0.pop_front() : sb_q1.pop_front();
            check_eq((d == 0) ? "sb_idx4" : "sb_idx8", {24'd0, ix}, exp_idx);
         end
      end
      prev_v[d] = (v === 1'b1);
   endtask

   always @(negedge CLK) begin
      check_outputs(0, valid4, {4'd0, grant4}, {6'd0, idx4}, busy4);
      check_outputs(1, valid8, grant8, {5'd0, idx8}, busy8);
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_grant(input int d);
      int n;
      n = 0;
      while (((d == 0) ? valid4 : valid8) !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      if (n >= 20) check_eq("wait_grant_timeout", 32'd0, 32'd1);
   endtask

   int seq [5];
   int exp4 [5] = '{0, 1, 2, 3, 0};
   int exp8 [5] = '{5, 6, 7, 0, 1};

   initial begin
      RESET = 1'b1; req4 = 4'd0; rel4 = 1'b0; req8 = 8'd0; rel8 = 1'b0;
      tick(); tick();
      RESET = 1'b0;

      // Idle after reset
      repeat (5) tick();
      check_eq("t1_idle_grant", {28'd0, grant4}, 32'd0);
      check_eq("t1_idle_valid", {31'd0, valid4}, 32'd0);
      check_eq("t1_cnt_zero", dut4.cnt_r, 32'd0);

      // Tie on ptr=0, then the passed-over guard wins
      req4 = 4'b0110;
      tick();
      check_eq("t3_first", {30'd0, idx4}, 32'd1);
      rel4 = 1'b1; tick(); rel4 = 1'b0;
      tick();
      check_eq("t3_second", {30'd0, idx4}, 32'd2);
      rel4 = 1'b1; req4 = 4'd0; tick(); rel4 = 1'b0;
      tick();

      // Round-robin under full load from reset
      RESET = 1'b1; tick(); RESET = 1'b0;
      req4 = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         wait_grant(0);
         seq[i] = idx4;
         rel4 = 1'b1; tick(); rel4 = 1'b0;
         check_eq("t2_idle_gap", {31'd0, valid4}, 32'd0);
      end
      for (int i = 0; i < 5; i++) check_eq("t2_seq", seq[i], exp4[i]);
      req4 = 4'd0;
      tick();

      // Grant held while its req drops
      RESET = 1'b1; tick(); RESET = 1'b0;
      req4 = 4'b0100;
      tick();
      check_eq("t4_grant", {28'd0, grant4}, 32'h4);
      req4 = 4'b0000;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("t4_hold", {28'd0, grant4}, 32'h4);
      end
      rel4 = 1'b1; tick(); rel4 = 1'b0;
      check_eq("t4_released", {28'd0, grant4}, 32'h0);

      // Release in IDLE ignored; release with new req goes through IDLE first
      rel4 = 1'b1; tick(); rel4 = 1'b0;
      check_eq("t5_idle_rel", {31'd0, valid4}, 32'd0);
      req4 = 4'b0001;
      tick();
      check_eq("t5_grant0", {28'd0, grant4}, 32'h1);
      req4 = 4'b1000; rel4 = 1'b1;
      tick();
      rel4 = 1'b0;
      check_eq("t5_idle_first", {31'd0, valid4}, 32'd0);
      tick();
      check_eq("t5_regrant", {30'd0, idx4}, 32'd3);

      // Reset mid-grant drops the grant at that edge
      RESET = 1'b1; tick();
      check_eq("t1_reset_midgrant", {28'd0, grant4}, 32'h0);
      RESET = 1'b0; req4 = 4'd0;
      tick();

      // Counter saturation with CNT_W=2: guard 3 loses five arbitrations in a row
      req8 = 8'h10;
      tick();
      check_eq("t6_pre", {29'd0, idx8}, 32'd4);
      rel8 = 1'b1; req8 = 8'hFF; tick(); rel8 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         wait_grant(1);
         seq[i] = idx8;
         rel8 = 1'b1; tick(); rel8 = 1'b0;
      end
      for (int i = 0; i < 5; i++) check_eq("t6_seq", seq[i], exp8[i]);
      check_eq("t6_cnt3_sat", {30'd0, dut8.cnt_r[7:6]}, 32'd3);
      req8 = 8'd0;
      repeat (3) tick();

      check_eq("sb_drained", sb_q0.size() + sb_q1.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
